regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DATA_WIDTH, default 192, width of the parallel load word and the shift register.
REQ-002 Parameter: CNT_W, default $clog2(DATA_WIDTH+1), width of the remaining-bit counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  0 = parallel load, 1 = shift one bit per clock.
REQ-006 Port: data_in  input  DATA_WIDTH  parallel word captured while en=0.
REQ-007 Port: shift_out  output  1  serial data; always equals the MSB of the internal shift register.
REQ-008 Port: bits_left  output  CNT_W  count of valid bits not yet fully presented, including the bit currently on shift_out.
REQ-009 Port: shift_valid  output  1  high when bits_left != 0.
REQ-010 Port: shift_done  output  1  high when bits_left == 0.

Function
REQ-011 Storage: one DATA_WIDTH-bit register sr; shift_out SHALL be sr[DATA_WIDTH-1], driven directly from the flop with no combinational input path.
REQ-012 Load: at each rising edge with en=0, sr <= data_in and bits_left <= DATA_WIDTH; loading repeats every cycle en stays 0, so the last word before en rises wins.
REQ-013 Shift: at each rising edge with en=1 and bits_left != 0, sr <= {sr[DATA_WIDTH-2:0], 1'b0} (MSB first, zero fill) and bits_left decrements by 1.
REQ-014 Exhausted: with en=1 and bits_left == 0, sr and bits_left SHALL hold; shift_out stays 0.
REQ-015 Latency: first bit (data_in[DATA_WIDTH-1]) appears on shift_out one edge after load; bit k appears k edges after the first shifting edge.
REQ-016 After DATA_WIDTH shifting edges following a load, bits_left = 0, shift_done = 1, shift_out = 0.
REQ-017 en toggling 1->0 mid-shift SHALL abort the stream and reload from data_in on that edge; no partial state is kept.
REQ-018 shift_valid and shift_done SHALL be mutually exclusive and decode combinationally from bits_left.
REQ-019 data_in changes while en=1 SHALL have no effect.

Reset
REQ-020 rst_n low SHALL immediately clear sr to 0 and bits_left to 0, so shift_out = 0, shift_valid = 0, shift_done = 1.
REQ-021 Reset deassertion SHALL not itself load; the first load occurs on the first rising edge with en=0.
REQ-022 Reset asserted mid-shift SHALL discard the stream; nothing resumes after release.

Structure
REQ-023 Package regfile_pkg SHALL hold DATA_WIDTH default, CNT_W derivation, and the en encoding constants (EN_LOAD=0, EN_SHIFT=1).
REQ-024 One sub-module regfile_bit_counter SHALL implement bits_left (load to DATA_WIDTH, saturating decrement, async clear); the shift register stays in the top.

Verification
REQ-025 Reset: rst_n=0 with en=1 -> shift_out=0, bits_left=0, shift_done=1 without any clock edge.
REQ-026 Load then shift 192'h123456789123456789ABCDEF123456789123456789ABCDEF: en=0 one cycle, then en=1 -> shift_out sequence begins 0,0,0,1,0,0,1,0 (0x12) and its last four bits are 1,1,1,1 (0xF).
REQ-027 Full drain: after 192 shifting edges -> shift_done=1, shift_out=0; 800 further edges with en=1 -> outputs unchanged.
REQ-028 Mid-stream reload: after 50 shifts, en=0 with data_in = all ones -> next edge bits_left=192, shift_out=1.
REQ-029 Async reset mid-shift: assert rst_n=0 between edges after 100 shifts -> outputs clear at once; after release with en=1, shift_out stays 0.
REQ-030 Reconstruct: capture 192 serial bits after a random load -> reassembled word equals data_in exactly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the serializing register file: default width,
// counter width derivation and the en encoding.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 192;
  localparam int CNT_W_DEF      = $clog2(DATA_WIDTH_DEF + 1);

  localparam logic EN_LOAD  = 1'b0;
  localparam logic EN_SHIFT = 1'b1;

  // Width needed to hold the values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/regfile_bit_counter.sv
// Remaining-bit counter: loads the full word length, counts down to zero
// and holds there.
module regfile_bit_counter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(DATA_WIDTH);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile.sv
// Parallel-load, MSB-first serializer. shift_out comes straight from the
// MSB flop; bits_left counts the bits still to be presented.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  shift_out,
  output logic [CNT_W-1:0]      bits_left,
  output logic                  shift_valid,
  output logic                  shift_done
);

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_d;
  logic                  load;
  logic                  shifting;

  assign load     = (en == EN_LOAD);
  assign shifting = (en == EN_SHIFT) && (bits_left != '0);

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = data_in;
    end else if (shifting) begin
      sr_d = {sr_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  regfile_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dec   (shifting),
    .cnt   (bits_left)
  );

  assign shift_out   = sr_q[DATA_WIDTH-1];
  assign shift_valid = (bits_left != '0);
  assign shift_done  = (bits_left == '0);

endmodule

// File: tb/tb_regfile.sv
// Randomized bench for the regfile serializer against a word/index model.
module tb_regfile;

  localparam int W  = 192;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  data_in;
  logic          shift_out;
  logic [CW-1:0] bits_left;
  logic          shift_valid;
  logic          shift_done;

  int total = 0;
  int bad   = 0;

  // Model: the last loaded word and how many bits have been shifted out.
  logic [W-1:0] ref_word;
  int           ref_idx;

  logic [W-1:0] cap;
  logic [W-1:0] kword;

  regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_in     (data_in),
    .shift_out   (shift_out),
    .bits_left   (bits_left),
    .shift_valid (shift_valid),
    .shift_done  (shift_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W / 32; i++) w = {w[W-33:0], 32'($urandom)};
    return w;
  endfunction

  function automatic logic exp_so();
    return (ref_idx < W) ? ref_word[W-1-ref_idx] : 1'b0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_so"}, shift_out, exp_so());
    chk({tag, "_bl"}, bits_left, W - ref_idx);
    chk({tag, "_vld"}, shift_valid, (ref_idx < W));
    chk({tag, "_done"}, shift_done, (ref_idx >= W));
  endtask

  task automatic model_reset();
    ref_word = '0;
    ref_idx  = W;
  endtask

  // One clock: drive inputs, take the edge, advance the model, check outputs.
  task automatic cyc(input logic e, input logic [W-1:0] d, input string tag);
    en      = e;
    data_in = d;
    @(posedge clk);
    #1;
    if (!e) begin
      ref_word = d;
      ref_idx  = 0;
    end else if (ref_idx < W) begin
      ref_idx++;
    end
    check_all(tag);
  endtask

  initial begin
    rst_n   = 1'b1;
    en      = 1'b1;
    data_in = '0;
    model_reset();

    // Reset with no clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_so", shift_out, 1'b0);
    chk("rst_bl", bits_left, 0);
    chk("rst_done", shift_done, 1'b1);
    chk("rst_vld", shift_valid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_all("post_rst");
    cyc(1'b1, rand_word(), "idle_after_rst");

    // Known word: first byte and last nibble of the serial stream
    kword = 192'h123456789123456789ABCDEF123456789123456789ABCDEF;
    cyc(1'b0, kword, "kload");
    cap = '0;
    cap = {cap[W-2:0], shift_out};
    for (int i = 1; i < W; i++) begin
      cyc(1'b1, rand_word(), "kshift");
      cap = {cap[W-2:0], shift_out};
    end
    chk("k_first_byte", cap[W-1 -: 8], 8'h12);
    chk("k_last_nib", cap[3:0], 4'hF);
    chk("k_word", cap, kword);
    cyc(1'b1, rand_word(), "kdrain");
    chk("drain_done", shift_done, 1'b1);
    chk("drain_so", shift_out, 1'b0);
    for (int i = 0; i < 800; i++) cyc(1'b1, rand_word(), "hold");
    chk("hold_bl", bits_left, 0);

    // Mid-stream reload with all ones
    cyc(1'b0, rand_word(), "mload");
    for (int i = 0; i < 50; i++) cyc(1'b1, rand_word(), "mshift");
    cyc(1'b0, {W{1'b1}}, "reload");
    chk("reload_bl", bits_left, W);
    chk("reload_so", shift_out, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, rand_word(), "ones");

    // Async reset mid-shift
    cyc(1'b0, {W{1'b1}} ^ rand_word(), "aload");
    for (int i = 0; i < 100; i++) cyc(1'b1, rand_word(), "ashift");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_so", shift_out, 1'b0);
    chk("arst_bl", bits_left, 0);
    chk("arst_done", shift_done, 1'b1);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1, rand_word(), "after_arst");
    chk("after_arst_so", shift_out, 1'b0);

    // Reconstruct random words
    for (int r = 0; r < 3; r++) begin
      kword = rand_word();
      cyc(1'b0, kword, "rload");
      cap = {cap[W-2:0], shift_out};
      for (int i = 1; i < W; i++) begin
        cyc(1'b1, rand_word(), "rshift");
        cap = {cap[W-2:0], shift_out};
      end
      chk("recon", cap, kword);
    end

    // Random en traffic, mostly shifting with occasional reloads
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 19) != 0), rand_word(), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
